// File: rtl/task_dispatch_ctrl_pkg.sv
// Shared definitions for the task dispatch controller: default ranges, fence bit
// positions and the dispatch FSM state type.
package task_dispatch_ctrl_pkg;

   localparam int unsigned CORES_DEF = 16;
   localparam int unsigned R0_W_DEF  = 8;
   localparam int unsigned CNT_W_DEF = 8;

   localparam int unsigned FENCE_W       = 2;
   localparam int unsigned FENCE_ACQ_BIT = 0;
   localparam int unsigned FENCE_REL_BIT = 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_ISSUE
   } disp_state_t;

endpackage

// File: rtl/task_dispatch_ctrl_busy.sv
// Per-core busy and release-fence tracking: a core becomes busy when started and
// is released on the next rising edge of its Ready line.
module core_busy_tracker
   import task_dispatch_ctrl_pkg::*;
#(
   parameter int unsigned CORES = CORES_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [CORES-1:0] core_ready,
   input  logic [CORES-1:0] set_mask,
   input  logic             set_rel,
   output logic [CORES-1:0] busy,
   output logic [CORES-1:0] rel_mask
);

   logic [CORES-1:0] core_ready_q;
   logic [CORES-1:0] rise;

   assign rise = core_ready & ~core_ready_q;

   // Set and clear never coincide on one bit: a busy core is never started.
   always_ff @(posedge clk) begin
      if (reset) begin
         core_ready_q <= '1;
         busy         <= '0;
         rel_mask     <= '0;
      end else begin
         core_ready_q <= core_ready;
         busy         <= (busy & ~rise) | set_mask;
         rel_mask     <= (rel_mask & ~rise) | ({CORES{set_rel}} & set_mask);
      end
   end

endmodule

// File: rtl/task_dispatch_ctrl.sv
// Dispatches one decoded task header to the core array once its target cores are
// idle and its fences allow, then issues a one-cycle start pulse with the R0 value.
module task_dispatch_ctrl
   import task_dispatch_ctrl_pkg::*;
#(
   parameter int unsigned CORES = CORES_DEF,
   parameter int unsigned R0_W  = R0_W_DEF,
   parameter int unsigned CNT_W = CNT_W_DEF
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               task_valid,
   output logic               task_ack,
   input  logic [CORES-1:0]   task_mask,
   input  logic [FENCE_W-1:0] task_fence,
   input  logic [R0_W-1:0]    task_r0,
   input  logic [CORES-1:0]   core_ready,
   output logic [CORES-1:0]   start,
   output logic [R0_W-1:0]    init_r0,
   output logic [CORES-1:0]   busy,
   output logic               rel_pending,
   output logic [CNT_W-1:0]   dispatch_cnt
);

   disp_state_t        state;
   logic [CORES-1:0]   mask_q;
   logic [FENCE_W-1:0] fence_q;
   logic [R0_W-1:0]    r0_q;
   logic [CORES-1:0]   rel_mask;
   logic               can_issue;
   logic               set_rel;

   // start is only non-zero during ISSUE, so it doubles as the busy set vector.
   assign set_rel = (state == ST_ISSUE) && fence_q[FENCE_REL_BIT];

   core_busy_tracker #(
      .CORES (CORES)
   ) u_busy (
      .clk        (clk),
      .reset      (reset),
      .core_ready (core_ready),
      .set_mask   (start),
      .set_rel    (set_rel),
      .busy       (busy),
      .rel_mask   (rel_mask)
   );

   assign rel_pending = |rel_mask;

   always_comb begin
      can_issue = ((core_ready & mask_q) == mask_q)
               && ((busy & mask_q) == '0)
               && (!fence_q[FENCE_ACQ_BIT] || (busy == '0))
               && (rel_mask == '0);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= ST_IDLE;
         task_ack     <= 1'b1;
         start        <= '0;
         init_r0      <= '0;
         dispatch_cnt <= '0;
         mask_q       <= '0;
         fence_q      <= '0;
         r0_q         <= '0;
      end else begin
         start <= '0;
         case (state)
            ST_IDLE: begin
               if (task_valid) begin
                  mask_q  <= task_mask;
                  fence_q <= task_fence;
                  r0_q    <= task_r0;
                  if (task_mask != '0) begin
                     state    <= ST_WAIT;
                     task_ack <= 1'b0;
                  end
               end
            end
            ST_WAIT: begin
               if (can_issue) begin
                  state        <= ST_ISSUE;
                  start        <= mask_q;
                  init_r0      <= r0_q;
                  dispatch_cnt <= dispatch_cnt + CNT_W'(1);
               end
            end
            ST_ISSUE: begin
               state    <= ST_IDLE;
               task_ack <= 1'b1;
            end
            default: begin
               state    <= ST_IDLE;
               task_ack <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_task_dispatch_ctrl.sv
// Bench for task_dispatch_ctrl: directed scenarios plus randomized traffic checked
// against a task-level reference model.
module tb_task_dispatch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        task_valid;
   logic        task_ack;
   logic [15:0] task_mask;
   logic [1:0]  task_fence;
   logic [7:0]  task_r0;
   logic [15:0] core_ready;
   logic [15:0] start;
   logic [7:0]  init_r0;
   logic [15:0] busy;
   logic        rel_pending;
   logic [7:0]  dispatch_cnt;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   task_dispatch_ctrl #(
      .CORES (16),
      .R0_W  (8),
      .CNT_W (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .task_valid   (task_valid),
      .task_ack     (task_ack),
      .task_mask    (task_mask),
      .task_fence   (task_fence),
      .task_r0      (task_r0),
      .core_ready   (core_ready),
      .start        (start),
      .init_r0      (init_r0),
      .busy         (busy),
      .rel_pending  (rel_pending),
      .dispatch_cnt (dispatch_cnt)
   );

   // Reference model: one pending task, a set of running cores and a set of
   // release-fenced cores; a task launches once its rules are satisfied.
   typedef struct packed {
      logic        ack;
      logic [15:0] start;
      logic [7:0]  r0;
      logic [15:0] busy;
      logic [15:0] rel;
      logic [7:0]  cnt;
      logic [15:0] prev_ready;
      logic        pend;
      logic        issuing;
      logic [15:0] tmask;
      logic [1:0]  tfence;
      logic [7:0]  tr0;
   } mdl_t;

   mdl_t m;

   function automatic mdl_t model_next(input mdl_t s, input logic rst, input logic v,
                                       input logic [15:0] mask, input logic [1:0] f,
                                       input logic [7:0] r0, input logic [15:0] rdy);
      mdl_t        n;
      logic [15:0] finished;
      n = s;
      if (rst) begin
         n = '0;
         n.ack = 1'b1;
         n.prev_ready = 16'hFFFF;
         return n;
      end
      finished     = rdy & ~s.prev_ready;
      n.prev_ready = rdy;
      n.busy       = (s.busy & ~finished) | s.start;
      n.rel        = (s.rel & ~finished) | (s.tfence[1] ? s.start : 16'h0000);
      n.start      = 16'h0000;
      if (s.issuing) begin
         n.issuing = 1'b0;
         n.ack     = 1'b1;
      end else if (s.pend) begin
         if (((rdy & s.tmask) == s.tmask) && ((s.busy & s.tmask) == 16'h0000) &&
             (!s.tfence[0] || s.busy == 16'h0000) && s.rel == 16'h0000) begin
            n.start   = s.tmask;
            n.r0      = s.tr0;
            n.cnt     = s.cnt + 8'd1;
            n.pend    = 1'b0;
            n.issuing = 1'b1;
         end
      end else if (v && mask != 16'h0000) begin
         n.pend   = 1'b1;
         n.tmask  = mask;
         n.tfence = f;
         n.tr0    = r0;
         n.ack    = 1'b0;
      end
      return n;
   endfunction

   always @(posedge clk)
      m <= model_next(m, reset, task_valid, task_mask, task_fence, task_r0, core_ready);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic release_all();
      core_ready = 16'h0000;
      tick();
      core_ready = 16'hFFFF;
      tick();
   endtask

   task automatic occupy(input logic [15:0] mask);
      task_valid = 1'b1; task_mask = mask; task_fence = 2'b00; task_r0 = 8'h00;
      tick();
      task_valid = 1'b0;
      tick();
      core_ready = core_ready & ~mask;
      tick();
   endtask

   task automatic test_reset();
      reset = 1'b1; task_valid = 1'b0; task_mask = '0; task_fence = '0; task_r0 = '0;
      core_ready = 16'hFFFF;
      tick(); tick();
      checks++; if (task_ack !== 1'b1) begin fails++; $display("FAIL reset_ack got %b want 1", task_ack); end
      checks++; if (start !== 16'h0000) begin fails++; $display("FAIL reset_start got %h want 0000", start); end
      checks++; if (busy !== 16'h0000) begin fails++; $display("FAIL reset_busy got %h want 0000", busy); end
      checks++; if (rel_pending !== 1'b0) begin fails++; $display("FAIL reset_rel got %b want 0", rel_pending); end
      checks++; if (dispatch_cnt !== 8'h00) begin fails++; $display("FAIL reset_cnt got %h want 00", dispatch_cnt); end
      checks++; if (init_r0 !== 8'h00) begin fails++; $display("FAIL reset_r0 got %h want 00", init_r0); end
      reset = 1'b0;
   endtask

   task automatic test_basic();
      task_valid = 1'b1; task_mask = 16'hAAAA; task_fence = 2'b00; task_r0 = 8'h5A;
      tick();
      task_valid = 1'b0;
      checks++; if (start !== 16'h0000) begin fails++; $display("FAIL basic_early got %h want 0000", start); end
      checks++; if (task_ack !== 1'b0) begin fails++; $display("FAIL basic_ack_wait got %b want 0", task_ack); end
      tick();
      checks++; if (start !== 16'hAAAA) begin fails++; $display("FAIL basic_start got %h want AAAA", start); end
      checks++; if (init_r0 !== 8'h5A) begin fails++; $display("FAIL basic_r0 got %h want 5A", init_r0); end
      checks++; if (dispatch_cnt !== 8'h01) begin fails++; $display("FAIL basic_cnt got %h want 01", dispatch_cnt); end
      tick();
      checks++; if (busy !== 16'hAAAA) begin fails++; $display("FAIL basic_busy got %h want AAAA", busy); end
      checks++; if (start !== 16'h0000) begin fails++; $display("FAIL basic_pulse got %h want 0000", start); end
      checks++; if (task_ack !== 1'b1) begin fails++; $display("FAIL basic_ack got %b want 1", task_ack); end
      core_ready = 16'h5555;
      tick();
      core_ready = 16'hFFFF;
      tick();
      checks++; if (busy !== 16'h0000) begin fails++; $display("FAIL basic_clear got %h want 0000", busy); end
   endtask

   task automatic test_busy_core();
      occupy(16'h0001);
      checks++; if (busy !== 16'h0001) begin fails++; $display("FAIL busy_setup got %h want 0001", busy); end
      task_valid = 1'b1; task_mask = 16'h0003; task_r0 = 8'h33;
      tick();
      task_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (start !== 16'h0000) begin fails++; $display("FAIL busy_hold got %h want 0000", start); end
      end
      core_ready = 16'hFFFF;
      tick();
      checks++; if (start !== 16'h0000) begin fails++; $display("FAIL busy_edge got %h want 0000", start); end
      tick();
      checks++; if (start !== 16'h0003) begin fails++; $display("FAIL busy_start got %h want 0003", start); end
      release_all();
      checks++; if (busy !== 16'h0000) begin fails++; $display("FAIL busy_clear got %h want 0000", busy); end
   endtask

   task automatic test_acq();
      occupy(16'h00F0);
      task_valid = 1'b1; task_mask = 16'h0F00; task_fence = 2'b01;
      tick();
      task_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (start !== 16'h0000) begin fails++; $display("FAIL acq_hold got %h want 0000", start); end
      end
      core_ready = 16'hFFFF;
      tick();
      checks++; if (start !== 16'h0000) begin fails++; $display("FAIL acq_edge got %h want 0000", start); end
      tick();
      checks++; if (start !== 16'h0F00) begin fails++; $display("FAIL acq_start got %h want 0F00", start); end
      release_all();
      occupy(16'h00F0);
      task_valid = 1'b1; task_mask = 16'h0F00; task_fence = 2'b00;
      tick();
      task_valid = 1'b0;
      checks++; if (start !== 16'h0000) begin fails++; $display("FAIL nofence_early got %h want 0000", start); end
      tick();
      checks++; if (start !== 16'h0F00) begin fails++; $display("FAIL nofence_start got %h want 0F00", start); end
      release_all();
   endtask

   task automatic test_rel();
      task_valid = 1'b1; task_mask = 16'h0001; task_fence = 2'b10;
      tick();
      task_valid = 1'b0;
      tick();
      core_ready = 16'hFFFE;
      tick();
      checks++; if (rel_pending !== 1'b1) begin fails++; $display("FAIL rel_set got %b want 1", rel_pending); end
      task_valid = 1'b1; task_mask = 16'h0002; task_fence = 2'b00;
      tick();
      task_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (start !== 16'h0000) begin fails++; $display("FAIL rel_hold got %h want 0000", start); end
         checks++; if (rel_pending !== 1'b1) begin fails++; $display("FAIL rel_pend got %b want 1", rel_pending); end
      end
      core_ready = 16'hFFFF;
      tick();
      checks++; if (rel_pending !== 1'b0) begin fails++; $display("FAIL rel_clear got %b want 0", rel_pending); end
      tick();
      checks++; if (start !== 16'h0002) begin fails++; $display("FAIL rel_start got %h want 0002", start); end
      release_all();
   endtask

   task automatic test_nop_wrap();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      task_valid = 1'b1; task_mask = 16'h0000; task_fence = 2'b00;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (task_ack !== 1'b1) begin fails++; $display("FAIL nop_ack got %b want 1", task_ack); end
         checks++; if (start !== 16'h0000) begin fails++; $display("FAIL nop_start got %h want 0000", start); end
         checks++; if (dispatch_cnt !== 8'h00) begin fails++; $display("FAIL nop_cnt got %h want 00", dispatch_cnt); end
      end
      task_valid = 1'b0;
      for (int k = 1; k <= 256; k++) begin
         task_valid = 1'b1; task_mask = 16'h0001; task_r0 = 8'(k);
         tick();
         task_valid = 1'b0;
         tick();
         checks++; if (start !== 16'h0001) begin fails++; $display("FAIL wrap_start k=%0d got %h want 0001", k, start); end
         checks++; if (dispatch_cnt !== 8'(k % 256)) begin fails++; $display("FAIL wrap_cnt k=%0d got %h want %h", k, dispatch_cnt, 8'(k % 256)); end
         core_ready = 16'hFFFE;
         tick();
         core_ready = 16'hFFFF;
         tick();
      end
   endtask

   task automatic test_reset_mid();
      occupy(16'h0001);
      task_valid = 1'b1; task_mask = 16'h0001; task_fence = 2'b00; task_r0 = 8'hC3;
      tick();
      task_valid = 1'b0;
      tick();
      checks++; if (task_ack !== 1'b0) begin fails++; $display("FAIL rstmid_wait got %b want 0", task_ack); end
      reset = 1'b1;
      tick();
      checks++; if (start !== 16'h0000) begin fails++; $display("FAIL rstmid_start got %h want 0000", start); end
      checks++; if (busy !== 16'h0000) begin fails++; $display("FAIL rstmid_busy got %h want 0000", busy); end
      checks++; if (task_ack !== 1'b1) begin fails++; $display("FAIL rstmid_ack got %b want 1", task_ack); end
      reset = 1'b0;
      core_ready = 16'hFFFF;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (start !== 16'h0000) begin fails++; $display("FAIL rstmid_never got %h want 0000", start); end
      end
   endtask

   task automatic test_random();
      int unsigned tmr [16];
      logic        acc;
      for (int i = 0; i < 16; i++) tmr[i] = 0;
      reset = 1'b1; task_valid = 1'b0; core_ready = 16'hFFFF;
      tick(); tick();
      reset = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         acc = task_valid && task_ack;
         tick();
         checks++; if (start !== m.start) begin fails++; $display("FAIL rnd_start c=%0d got %h want %h", c, start, m.start); end
         checks++; if (busy !== m.busy) begin fails++; $display("FAIL rnd_busy c=%0d got %h want %h", c, busy, m.busy); end
         checks++; if (task_ack !== m.ack) begin fails++; $display("FAIL rnd_ack c=%0d got %b want %b", c, task_ack, m.ack); end
         checks++; if (rel_pending !== (m.rel != 16'h0000)) begin fails++; $display("FAIL rnd_rel c=%0d got %b want %b", c, rel_pending, m.rel != 16'h0000); end
         checks++; if (dispatch_cnt !== m.cnt) begin fails++; $display("FAIL rnd_cnt c=%0d got %h want %h", c, dispatch_cnt, m.cnt); end
         checks++; if (init_r0 !== m.r0) begin fails++; $display("FAIL rnd_r0 c=%0d got %h want %h", c, init_r0, m.r0); end
         if (acc || !task_valid) begin
            if ($urandom_range(0, 2) == 0) begin
               task_valid = 1'b1;
               task_mask  = ($urandom_range(0, 9) == 0) ? 16'h0000 : 16'($urandom & $urandom);
               task_fence = 2'($urandom_range(0, 3));
               task_r0    = 8'($urandom);
            end else begin
               task_valid = 1'b0;
            end
         end
         for (int i = 0; i < 16; i++) begin
            if (start[i]) tmr[i] = $urandom_range(1, 5);
            else if (tmr[i] != 0) tmr[i] = tmr[i] - 1;
            else if ($urandom_range(0, 49) == 0) tmr[i] = 1;
            core_ready[i] = (tmr[i] == 0);
         end
      end
      task_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_busy_core();
      test_acq();
      test_rel();
      test_nop_wrap();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
